// File: rtl/ds_sinc3_decim.sv
// Third-order CIC (sinc3) decimator for the 1-bit delta-sigma PDM stream.
// Three chained integrators run on every PDM strobe. On each frame wrap the
// last integrator is snapshotted, and a small FSM runs the three comb stages
// over consecutive clocks through one shared subtractor. The result is then
// scaled to OUT_WIDTH bits with saturation.
//
// Handshake: cke is a one-clk qualifier for pdm_in (no backpressure).
// dout_valid is a one-clk pulse on the cycle dout takes a new value, and
// dout holds its value in between pulses.
module ds_sinc3_decim #(
  parameter int DECIM     = 64,
  parameter int OUT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cke,
  input  logic                 pdm_in,
  output logic [OUT_WIDTH-1:0] dout,
  output logic                 dout_valid,
  output logic                 settled,
  output logic [1:0]           dbg_state
);

  localparam int L   = $clog2(DECIM);
  localparam int W   = 3 * L + 2;
  localparam int SH  = 3 * L - (OUT_WIDTH - 1);
  localparam int SHR = (SH > 0) ? SH : 0;
  localparam int SHL = (SH < 0) ? -SH : 0;
  localparam int XW  = W + OUT_WIDTH;
  localparam logic signed [XW-1:0] SAT_HI = XW'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [XW-1:0] SAT_LO = ~SAT_HI;

  typedef enum logic [1:0] {IDLE = 2'd0, C1 = 2'd1, C2 = 2'd2, C3 = 2'd3} state_t;

  state_t               state_q, state_d;
  logic [W-1:0]         x;
  logic [W-1:0]         i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
  logic [L-1:0]         cnt_q, cnt_d;
  logic                 wrap;
  logic [W-1:0]         snap_q, snap_d;
  logic [W-1:0]         d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
  logic [W-1:0]         c_q, c_d;
  logic [W-1:0]         sub_a, sub_b, diff;
  logic signed [XW-1:0] ext, shf;
  logic [OUT_WIDTH-1:0] sat;
  logic [OUT_WIDTH-1:0] dout_q, dout_d;
  logic                 valid_q, valid_d;
  logic [1:0]           nout_q, nout_d;

  // Integrator chain and frame counter; all three sums use same-cycle new values.
  always_comb begin
    x     = pdm_in ? W'(1) : {W{1'b1}};
    i1_d  = i1_q;
    i2_d  = i2_q;
    i3_d  = i3_q;
    cnt_d = cnt_q;
    wrap  = 1'b0;
    if (cke) begin
      i1_d  = i1_q + x;
      i2_d  = i2_q + i1_d;
      i3_d  = i3_q + i2_d;
      cnt_d = cnt_q + 1'b1;
      wrap  = (cnt_q == L'(DECIM - 1));
    end
    snap_d = wrap ? i3_d : snap_q;
  end

  // Integrator, counter and snapshot registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      i1_q   <= '0;
      i2_q   <= '0;
      i3_q   <= '0;
      cnt_q  <= '0;
      snap_q <= '0;
    end else begin
      i1_q   <= i1_d;
      i2_q   <= i2_d;
      i3_q   <= i3_d;
      cnt_q  <= cnt_d;
      snap_q <= snap_d;
    end
  end

  // Operand select for the one subtractor shared by the three comb stages.
  always_comb begin
    sub_a = snap_q;
    sub_b = d1_q;
    case (state_q)
      C2:      begin sub_a = c_q; sub_b = d2_q; end
      C3:      begin sub_a = c_q; sub_b = d3_q; end
      default: begin sub_a = snap_q; sub_b = d1_q; end
    endcase
  end

  assign diff = sub_a - sub_b;

  // Scale the final comb output to OUT_WIDTH bits (floor shift) and saturate.
  always_comb begin
    ext = {{(XW - W){diff[W-1]}}, diff};
    shf = (ext >>> SHR) <<< SHL;
    if (shf > SAT_HI)      sat = SAT_HI[OUT_WIDTH-1:0];
    else if (shf < SAT_LO) sat = SAT_LO[OUT_WIDTH-1:0];
    else                   sat = shf[OUT_WIDTH-1:0];
  end

  // Comb FSM next state and datapath; a frame wrap always starts a new pass.
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    d3_d    = d3_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    nout_d  = nout_q;
    case (state_q)
      C1: begin
        c_d     = diff;
        d1_d    = snap_q;
        state_d = C2;
      end
      C2: begin
        c_d     = diff;
        d2_d    = c_q;
        state_d = C3;
      end
      C3: begin
        d3_d    = c_q;
        dout_d  = sat;
        valid_d = 1'b1;
        if (nout_q != 2'd3) nout_d = nout_q + 2'd1;
        state_d = IDLE;
      end
      default: ;
    endcase
    if (wrap) state_d = C1;
  end

  // Comb FSM state, comb delays and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      c_q     <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      d3_q    <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      nout_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      d3_q    <= d3_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      nout_q  <= nout_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign settled    = (nout_q == 2'd3);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_ds_sinc3_decim.sv
// Bench for ds_sinc3_decim: one DECIM=64 and one DECIM=4 instance. The
// reference is a direct FIR over the input history using the triple-boxcar
// kernel, followed by floor scaling and saturation.
module tb_ds_sinc3_decim;
  localparam int OW = 16;

  // Clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]    rst, cke, pdm, dout_valid, settled;
  logic [OW-1:0] dout64, dout4;
  logic [1:0]    st64, st4;
  int            cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ds_sinc3_decim #(.DECIM(64), .OUT_WIDTH(OW)) u_dut64 (
    .clk(clk), .rst(rst[0]), .cke(cke[0]), .pdm_in(pdm[0]), .dout(dout64),
    .dout_valid(dout_valid[0]), .settled(settled[0]), .dbg_state(st64));
  ds_sinc3_decim #(.DECIM(4), .OUT_WIDTH(OW)) u_dut4 (
    .clk(clk), .rst(rst[1]), .cke(cke[1]), .pdm_in(pdm[1]), .dout(dout4),
    .dout_valid(dout_valid[1]), .settled(settled[1]), .dbg_state(st4));

  // Scoreboard state
  int            n_tests = 0;
  int            n_fail  = 0;
  int            dl [2];
  int            h [2][190];
  int            hist [2][1024];
  int            nx [2];
  int            npulse [2];
  int            last_pc [2];
  int            prev_pc [2];
  logic [OW-1:0] last [2];
  logic [OW-1:0] exp_q0[$], exp_q1[$];
  int            cyc_q0[$], cyc_q1[$];

  task automatic check(string name, longint act, longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [OW-1:0] model_out(int inst);
    longint y = 0;
    longint v;
    int d  = dl[inst];
    int sh = 3 * $clog2(d) - (OW - 1);
    for (int k = 0; k < 3 * d - 2; k++)
      if (nx[inst] - 1 - k >= 0) y += longint'(h[inst][k]) * hist[inst][nx[inst] - 1 - k];
    if (sh >= 0) v = y >>> sh;
    else         v = y <<< (-sh);
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    return v[OW-1:0];
  endfunction

  // Driver tasks
  task automatic drive_bit(int inst, logic b, int spacing);
    @(negedge clk);
    cke[inst] = 1'b1;
    pdm[inst] = b;
    if (nx[inst] < 1024) begin
      hist[inst][nx[inst]] = b ? 1 : -1;
      nx[inst]++;
    end
    if (nx[inst] % dl[inst] == 0) begin
      if (inst == 0) begin exp_q0.push_back(model_out(0)); cyc_q0.push_back(cyc + 4); end
      else           begin exp_q1.push_back(model_out(1)); cyc_q1.push_back(cyc + 4); end
    end
    repeat (spacing - 1) begin
      @(negedge clk);
      cke[inst] = 1'b0;
      pdm[inst] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic idle(int inst, int n);
    repeat (n) begin
      @(negedge clk);
      cke[inst] = 1'b0;
    end
  endtask

  task automatic do_reset(int inst, int cycles);
    @(negedge clk);
    rst[inst]    = 1'b1;
    cke[inst]    = 1'b0;
    nx[inst]     = 0;
    npulse[inst] = 0;
    last[inst]   = '0;
    if (inst == 0) begin exp_q0.delete(); cyc_q0.delete(); end
    else           begin exp_q1.delete(); cyc_q1.delete(); end
    repeat (cycles) @(negedge clk);
    rst[inst] = 1'b0;
  endtask

  // Monitor: pops the expected queue on every pulse, checks hold otherwise
  task automatic mon(int inst, logic [OW-1:0] d, logic v, logic s);
    logic [OW-1:0] e;
    int            c;
    int            qn;
    qn = (inst == 0) ? exp_q0.size() : exp_q1.size();
    if (v) begin
      if (qn == 0) check($sformatf("unexpected_pulse%0d", inst), 1, 0);
      else begin
        if (inst == 0) begin e = exp_q0.pop_front(); c = cyc_q0.pop_front(); end
        else           begin e = exp_q1.pop_front(); c = cyc_q1.pop_front(); end
        check($sformatf("dout%0d", inst), longint'($signed(d)), longint'($signed(e)));
        check($sformatf("latency%0d", inst), cyc, c);
        last[inst] = e;
        npulse[inst]++;
        prev_pc[inst] = last_pc[inst];
        last_pc[inst] = cyc;
        check($sformatf("settled_at_pulse%0d", inst), s, (npulse[inst] >= 3) ? 1 : 0);
      end
    end else begin
      check($sformatf("dout_hold%0d", inst), longint'($signed(d)), longint'($signed(last[inst])));
      check($sformatf("settled_hold%0d", inst), s, (npulse[inst] >= 3) ? 1 : 0);
      if (qn > 0) begin
        c = (inst == 0) ? cyc_q0[0] : cyc_q1[0];
        if (cyc > c) begin
          check($sformatf("missed_pulse%0d", inst), cyc, c);
          if (inst == 0) begin void'(exp_q0.pop_front()); void'(cyc_q0.pop_front()); end
          else           begin void'(exp_q1.pop_front()); void'(cyc_q1.pop_front()); end
        end
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    mon(0, dout64, dout_valid[0], settled[0]);
    mon(1, dout4, dout_valid[1], settled[1]);
  end

  typedef struct {
    logic [3:0] pat;
    int         plen;
    int         spacing;
    int         frames;
    int         exp_out;
  } vec_t;

  vec_t tbl [4];

  initial begin
    rst = 2'b11; cke = 2'b00; pdm = 2'b00;
    last[0] = '0; last[1] = '0;
    dl[0] = 64; dl[1] = 4;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 190; k++) h[i][k] = 0;
      for (int a = 0; a < dl[i]; a++)
        for (int b = 0; b < dl[i]; b++)
          for (int c = 0; c < dl[i]; c++) h[i][a + b + c]++;
    end
    // spacing 0 selects a random 1..3 clk strobe spacing
    tbl[0] = '{4'b0001, 1, 100, 4,  32767};  // constant 1
    tbl[1] = '{4'b0000, 1, 0,   5, -32768};  // constant 0
    tbl[2] = '{4'b0001, 2, 0,   5,  0};      // 1,0 alternating
    tbl[3] = '{4'b0111, 4, 0,   5,  16384};  // 1,1,1,0

    repeat (3) @(negedge clk);
    rst = 2'b00;
    check("rst_dout64", dout64, 0);
    check("rst_valid64", dout_valid[0], 0);
    check("rst_settled64", settled[0], 0);
    check("rst_state64", st64, 0);
    check("rst_dout4", dout4, 0);
    check("rst_state4", st4, 0);

    // Table-driven steady-state vectors on the DECIM=64 instance
    for (int t = 0; t < 4; t++) begin
      do_reset(0, 2);
      for (int i = 0; i < tbl[t].frames * 64; i++)
        drive_bit(0, tbl[t].pat[i % tbl[t].plen],
                  (tbl[t].spacing == 0) ? int'($urandom_range(1, 3)) : tbl[t].spacing);
      idle(0, 6);
      check($sformatf("steady_dout_v%0d", t), longint'($signed(dout64)), tbl[t].exp_out);
      check($sformatf("settled_v%0d", t), settled[0], 1);
      check($sformatf("pulses_v%0d", t), npulse[0], tbl[t].frames);
      if (tbl[t].spacing == 100) check("pulse_period_64x100", last_pc[0] - prev_pc[0], 6400);
    end

    // Random PDM stream, random strobe spacing
    do_reset(0, 2);
    for (int i = 0; i < 4 * 64; i++) drive_bit(0, 1'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
    idle(0, 6);
    check("pulses_random64", npulse[0], 4);

    // DECIM=4 with cke tied high: back-to-back frames, none may be dropped
    do_reset(1, 2);
    for (int i = 0; i < 40 * 4; i++) drive_bit(1, 1'b1, 1);
    idle(1, 6);
    check("steady_dout_d4", longint'($signed(dout4)), 32767);
    check("pulses_d4", npulse[1], 40);
    check("pulse_period_d4", last_pc[1] - prev_pc[1], 4);
    do_reset(1, 2);
    for (int i = 0; i < 20 * 4; i++) drive_bit(1, 1'($urandom_range(0, 1)), 1);
    idle(1, 6);
    check("pulses_random_d4", npulse[1], 20);

    // One-clk reset in the middle of a frame during the 1,1,1,0 pattern
    do_reset(0, 2);
    for (int i = 0; i < 3 * 64 + 20; i++) drive_bit(0, tbl[3].pat[i % 4], 1);
    do_reset(0, 1);
    check("midrst_dout", dout64, 0);
    check("midrst_valid", dout_valid[0], 0);
    check("midrst_settled", settled[0], 0);
    check("midrst_state", st64, 0);
    for (int i = 0; i < 4 * 64; i++) drive_bit(0, tbl[3].pat[i % 4], int'($urandom_range(1, 2)));
    idle(0, 6);
    check("midrst_steady_dout", longint'($signed(dout64)), 16384);
    check("midrst_settled_after", settled[0], 1);
    check("midrst_pulses", npulse[0], 4);

    idle(0, 4);
    check("pending64", exp_q0.size(), 0);
    check("pending4", exp_q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
